// File: rtl/pcie_x1_evt_xfer_arb.sv
// Round-robin event arbiter: NUM_REQ f_clk event pulses share one four-phase req/ack crossing into s_clk.
// Latency: grant 1 f_clk after pend sets; out_vld on the 3rd s_clk edge after req_f rises (+1 s_clk sync uncertainty).
// Backpressure: one pending slot per requester; a repeat event while pending is dropped and flagged in ovf_flag.
module pcie_x1_evt_xfer_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               f_clk,
  input  logic               s_clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] evt_in,
  input  logic               ovf_clr,
  output logic               busy,
  output logic [NUM_REQ-1:0] ovf_flag,
  output logic               out_vld,
  output logic [ID_W-1:0]    out_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // f_clk domain state
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] ovf_q, ovf_d;
  logic [ID_W-1:0]    last_gnt_q, last_gnt_d;
  logic [ID_W-1:0]    id_f_q, id_f_d;
  logic               req_f_q, req_f_d;
  logic               ack_f1_q, ack_f2_q;

  // ---------------------------------------------------------------------------
  // s_clk domain state
  // ---------------------------------------------------------------------------
  logic               sreq1_q, sreq2_q, sreq3_q;
  logic               out_vld_q;
  logic [ID_W-1:0]    out_id_q;

  // Arbitration helpers
  logic               pick_vld;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] gnt_clr;
  logic [NUM_REQ-1:0] ovf_set;

  // Round-robin pick: pending requester with the smallest distance past last_gnt.
  always_comb begin
    int best;
    best     = NUM_REQ;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Distance 0 is last_gnt+1, distance NUM_REQ-1 is last_gnt itself.
      if (pend_q[i] && (((i + NUM_REQ - 1 - int'(last_gnt_q)) % NUM_REQ) < best)) begin
        best     = (i + NUM_REQ - 1 - int'(last_gnt_q)) % NUM_REQ;
        pick_vld = 1'b1;
        pick_idx = ID_W'(i);
      end
    end
  end

  // Handshake FSM next-state, grant issue and pending/overflow bookkeeping.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    id_f_d     = id_f_q;
    req_f_d    = req_f_q;
    gnt_clr    = '0;

    unique case (state_q)
      ST_IDLE: begin
        // id_f only moves here, while req_f and ack are both low, so the
        // s_clk side always samples a settled value.
        if (pick_vld) begin
          id_f_d     = pick_idx;
          last_gnt_d = pick_idx;
          gnt_clr    = NUM_REQ'(1) << pick_idx;
          req_f_d    = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_f2_q) begin
          req_f_d = 1'b0;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!ack_f2_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_f_d = 1'b0;
      end
    endcase

    // An event landing in the grant cycle re-arms the slot rather than overflowing.
    ovf_set = evt_in & pend_q & ~gnt_clr;
    pend_d  = (pend_q & ~gnt_clr) | evt_in;
    // A fresh overflow beats a simultaneous clear for its own bit.
    ovf_d   = (ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  // f_clk state registers; last_gnt resets to the top index so requester 0 wins first.
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      ovf_q      <= '0;
      last_gnt_q <= ID_W'(NUM_REQ - 1);
      id_f_q     <= '0;
      req_f_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      last_gnt_q <= last_gnt_d;
      id_f_q     <= id_f_d;
      req_f_q    <= req_f_d;
    end
  end

  // Ack synchronizer back into f_clk; the ack is the s_clk-side synchronized request.
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_f1_q <= 1'b0;
      ack_f2_q <= 1'b0;
    end else begin
      ack_f1_q <= sreq2_q;
      ack_f2_q <= ack_f1_q;
    end
  end

  // Request synchronizer into s_clk plus an edge-detect stage.
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      sreq1_q <= 1'b0;
      sreq2_q <= 1'b0;
      sreq3_q <= 1'b0;
    end else begin
      sreq1_q <= req_f_q;
      sreq2_q <= sreq1_q;
      sreq3_q <= sreq2_q;
    end
  end

  // One delivery strobe per request rising edge; id_f is stable by then.
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_id_q  <= '0;
    end else begin
      out_vld_q <= sreq2_q & ~sreq3_q;
      if (sreq2_q && !sreq3_q) begin
        out_id_q <= id_f_q;
      end
    end
  end

  assign busy     = (state_q != ST_IDLE) | (|pend_q);
  assign ovf_flag = ovf_q;
  assign out_vld  = out_vld_q;
  assign out_id   = out_id_q;

endmodule
